mdr_datapath: RTL and testbench
===============================

// Module: mdr_datapath
// PURPOSE
//  Multi-cycle arithmetic datapath driven by the `control` FSM through the CONTROL_SIGNALS bus.
//  It executes unsigned multiply, divide or integer square root one iteration per step
//  strobe. It returns the last_step status to the FSM, and it registers the result with a
//  one-cycle valid pulse.
//  It is the consumer end of the control/datapath interface. The FSM drives; this block responds.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 4
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          synchronous reset, active-low
//  control     in   CONTROL_SIGNALS  {init, step, store} strobes from control FSM
//  opc_code    in   2          operation select; sampled on init only
//  data_a      in   WIDTH      multiplicand / dividend / radicand; sampled on init
//  data_b      in   WIDTH      multiplier / divisor (ignored for sqrt); sampled on init
//  last_step   out  1          to FSM: the current step is the final iteration
//  result      out  2*WIDTH    product / quotient (zero-extended) / root (zero-extended)
//  remainder   out  WIDTH      div remainder / sqrt remainder (a - root^2) / 0 for mul
//  valid       out  1          1-cycle pulse, the cycle after store
//  error       out  1          div-by-zero or reserved opcode; held until next init
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): all internal registers and outputs are cleared.
//    result=0, remainder=0, valid=0, error=0, cnt=0, op_reg=OPC_MUL. Reset overrides
//    every strobe, including reset in the middle of an operation.
//  - Strobe priority, when strobes arrive in the same cycle: init > store > step.
//    The losing strobes are dropped.
//  - init: the block latches data_a, data_b and opc_code into op_reg. It clears acc and
//    cnt, and sets error = (op==OPC_DIV && data_b==0) || op==OPC_RSV.
//    init leaves result and remainder unchanged.
//  - ITER(op): WIDTH for MUL and DIV; WIDTH/2 for SQRT.
//  - step: the block performs one iteration and sets cnt<=cnt+1.
//    A step is ignored when error==1 or when cnt==ITER.
//  - MUL iteration: shift-add, LSB first. If b[cnt]==1, acc += a<<cnt. acc is 2*WIDTH
//    bits wide; the product is exact with no overflow.
//  - DIV iteration: restoring division, MSB first. The partial remainder shifts in the
//    next dividend bit. Subtract the divisor; if the difference is non-negative, keep it
//    and the quotient bit is 1. Otherwise restore, and the quotient bit is 0.
//  - SQRT iteration: digit-by-digit restoring sqrt, 2 radicand bits per step, MSB pair first.
//  - last_step: combinational, equal to (cnt==ITER(op_reg)-1) && !error.
//  - store: result and remainder are loaded from the working registers.
//    valid=1 on the following cycle only.
//    If error==1, result=0 and remainder=0 are stored, and valid still pulses.
//    A store before cnt==ITER stores the partial values. The block takes no corrective action.
//  - Latency: result is available ITER+2 cycles after init, given back-to-back step
//    strobes followed by store. valid rises one cycle after store.
//  - A new init during an operation aborts the operation silently and restarts.
// STRUCTURE
//  - Package Definitions holds the following items:
//      CONTROL_SIGNALS packed struct {logic init; logic step; logic store;}
//      opcode enum OPC_MUL=2'b00, OPC_DIV=2'b01, OPC_SQRT=2'b10, OPC_RSV=2'b11
//  - Sub-module mdr_iter_counter: a saturating counter from 0 to ITER, with clear and
//    increment inputs. It produces cnt and last_step.
//  - The three algorithms share the acc and working registers, which are multiplexed by op_reg.
// TESTING (WIDTH=8)
//  1. MUL: a=13, b=11, init, 8 steps, store -> result=143, remainder=0;
//     last_step high on the 8th step only; valid for 1 cycle.
//  2. DIV: a=200, b=7, init, 8 steps, store -> result=28, remainder=4, error=0.
//  3. SQRT: a=200, init, 4 steps, store -> result=14, remainder=4;
//     extra steps beyond 4 leave the values unchanged.
//  4. DIV: a=50, b=0 -> error=1 after init; last_step stays 0; after store,
//     result=0, remainder=0, valid pulses. The next init with OPC_MUL clears error.
//  5. Reset: rst=0 after the 4th step of a MUL -> all outputs are 0 next cycle.
//     Then a=3, b=5, full sequence -> result=15.
//  6. init+step in the same cycle -> cnt=0 and acc=0 afterward.
//     store+step in the same cycle -> the store happens and cnt is unchanged.

Source files
------------

// File: rtl/mdr_datapath_pkg.sv
// Shared types for the multiply/divide/sqrt datapath: control strobe bus, opcodes
// and the per-opcode iteration count.
package mdr_datapath_pkg;

   typedef struct packed {
      logic init;
      logic step;
      logic store;
   } CONTROL_SIGNALS;

   typedef enum logic [1:0] {
      OPC_MUL  = 2'b00,
      OPC_DIV  = 2'b01,
      OPC_SQRT = 2'b10,
      OPC_RSV  = 2'b11
   } opcode_t;

   // Square root consumes two radicand bits per iteration, so it needs half as many.
   function automatic int iter_of(input opcode_t op, input int width);
      return (op == OPC_SQRT) ? width / 2 : width;
   endfunction

endpackage

// File: rtl/mdr_iter_counter.sv
// Saturating iteration counter: counts 0..i_limit, flags the final iteration and completion.
module mdr_iter_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear,
   input  logic          i_inc,
   input  logic [CW-1:0] i_limit,
   output logic [CW-1:0] o_cnt,
   output logic          o_last,
   output logic          o_done
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != i_limit)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_done = (r_cnt == i_limit);
   assign o_last = (r_cnt == (i_limit - CW'(1)));

endmodule

// File: rtl/mdr_datapath.sv
// Multi-cycle unsigned multiply / restoring divide / restoring sqrt datapath, one
// iteration per step strobe from the control FSM; result registered with a valid pulse.
module mdr_datapath
   import mdr_datapath_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  CONTROL_SIGNALS       control,
   input  logic [1:0]           opc_code,
   input  logic [WIDTH-1:0]     data_a,
   input  logic [WIDTH-1:0]     data_b,
   output logic                 last_step,
   output logic [2*WIDTH-1:0]   result,
   output logic [WIDTH-1:0]     remainder,
   output logic                 valid,
   output logic                 error
);

   localparam int CW = $clog2(WIDTH + 1);

   opcode_t              r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]     r_remainder;
   logic                 r_valid;
   logic                 r_error;

   opcode_t              w_opIn;
   logic [CW-1:0]        w_cnt;
   logic [CW-1:0]        w_iter;
   logic                 w_last;
   logic                 w_done;
   logic                 w_store;
   logic                 w_step;
   logic [WIDTH-1:0]     w_bShift;
   logic [WIDTH-1:0]     w_aShift;
   logic [WIDTH-1:0]     w_aPair;
   logic [WIDTH:0]       w_divTrial;
   logic [WIDTH:0]       w_divDiff;
   logic [WIDTH+1:0]     w_sqTrial;
   logic [WIDTH+1:0]     w_sqSub;
   logic [WIDTH+1:0]     w_sqDiff;
   logic [2*WIDTH-1:0]   w_accNext;
   logic [2*WIDTH-1:0]   w_resultNext;
   logic [WIDTH-1:0]     w_remNext;

   // init beats store beats step; a step is also dropped on error or once all iterations ran.
   assign w_opIn  = opcode_t'(opc_code);
   assign w_store = control.store && !control.init;
   assign w_step  = control.step && !control.init && !control.store && !r_error && !w_done;
   assign w_iter  = CW'(iter_of(r_op, WIDTH));

   mdr_iter_counter #(.CW(CW)) u_counter (
      .clk     (clk),
      .rst     (rst),
      .i_clear (control.init),
      .i_inc   (w_step),
      .i_limit (w_iter),
      .o_cnt   (w_cnt),
      .o_last  (w_last),
      .o_done  (w_done)
   );

   // For DIV/SQRT, acc holds {partial remainder, quotient/root}; for MUL it is the product.
   assign w_bShift   = r_b >> w_cnt;
   assign w_aShift   = r_a << w_cnt;
   assign w_aPair    = r_a << {w_cnt, 1'b0};
   assign w_divTrial = {r_acc[2*WIDTH-1:WIDTH], w_aShift[WIDTH-1]};
   assign w_divDiff  = w_divTrial - {1'b0, r_b};
   assign w_sqTrial  = {r_acc[2*WIDTH-1:WIDTH], w_aPair[WIDTH-1:WIDTH-2]};
   assign w_sqSub    = {r_acc[WIDTH-1:0], 2'b01};
   assign w_sqDiff   = w_sqTrial - w_sqSub;

   always_comb begin
      w_accNext = r_acc;
      case (r_op)
         OPC_MUL: begin
            if (w_bShift[0]) begin
               w_accNext = r_acc + ({{WIDTH{1'b0}}, r_a} << w_cnt);
            end
         end
         OPC_DIV: begin
            if (w_divTrial >= {1'b0, r_b}) begin
               w_accNext = {w_divDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
               w_accNext = {w_divTrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
         end
         OPC_SQRT: begin
            if (w_sqTrial >= w_sqSub) begin
               w_accNext = {w_sqDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
               w_accNext = {w_sqTrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
         end
         default: w_accNext = r_acc;
      endcase
   end

   always_comb begin
      w_resultNext = '0;
      w_remNext    = '0;
      case (r_op)
         OPC_MUL: w_resultNext = r_acc;
         OPC_DIV, OPC_SQRT: begin
            w_resultNext = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
            w_remNext    = r_acc[2*WIDTH-1:WIDTH];
         end
         default: begin
            w_resultNext = '0;
            w_remNext    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op        <= OPC_MUL;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_result    <= '0;
         r_remainder <= '0;
         r_valid     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_valid <= w_store;
         if (control.init) begin
            r_op    <= w_opIn;
            r_a     <= data_a;
            r_b     <= data_b;
            r_acc   <= '0;
            r_error <= ((w_opIn == OPC_DIV) && (data_b == '0)) || (w_opIn == OPC_RSV);
         end else if (w_store) begin
            r_result    <= r_error ? '0 : w_resultNext;
            r_remainder <= r_error ? '0 : w_remNext;
         end else if (w_step) begin
            r_acc <= w_accNext;
         end
      end
   end

   assign last_step = w_last && !r_error;
   assign result    = r_result;
   assign remainder = r_remainder;
   assign valid     = r_valid;
   assign error     = r_error;

endmodule

// File: tb/tb_mdr_datapath.sv
// Self-checking bench for mdr_datapath: directed vector table, hand-written corner
// sequences and randomized operations compared against an arithmetic reference model.
module tb_mdr_datapath;
   import mdr_datapath_pkg::*;

   localparam int W = 8;

   logic              clk = 1'b0;
   logic              rst;
   CONTROL_SIGNALS    control;
   logic [1:0]        opc;
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic              lastStep;
   logic [2*W-1:0]    result;
   logic [W-1:0]      remainder;
   logic              valid;
   logic              error;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      int          steps;
      int          expRes;
      int          expRem;
      int          expErr;
   } vec_t;

   mdr_datapath #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .control   (control),
      .opc_code  (opc),
      .data_a    (a),
      .data_b    (b),
      .last_step (lastStep),
      .result    (result),
      .remainder (remainder),
      .valid     (valid),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic int iterOf(input logic [1:0] op);
      return (op == 2'b10) ? W / 2 : W;
   endfunction

   // Plain arithmetic view of what each opcode should produce.
   task automatic refModel(input logic [1:0] op, input int ai, input int bi,
                           output int res, output int rem, output int err);
      int r;
      res = 0; rem = 0; err = 0;
      case (op)
         2'b00: res = ai * bi;
         2'b01: begin
            if (bi == 0) err = 1;
            else begin res = ai / bi; rem = ai % bi; end
         end
         2'b10: begin
            r = 0;
            while ((r + 1) * (r + 1) <= ai) r++;
            res = r;
            rem = ai - r * r;
         end
         default: err = 1;
      endcase
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input int nSteps, input bit doStore,
                                output int errInit, output int lastHits, output int lastAt);
      control      = '0;
      control.init = 1'b1;
      opc          = op;
      a            = ai;
      b            = bi;
      tick();
      control  = '0;
      errInit  = int'(error);
      lastHits = 0;
      lastAt   = -1;
      for (int i = 1; i <= nSteps; i++) begin
         control.step = 1'b1;
         #1;
         if (lastStep) begin
            lastHits++;
            lastAt = i;
         end
         tick();
         control.step = 1'b0;
      end
      if (doStore) begin
         control.store = 1'b1;
         tick();
         control.store = 1'b0;
      end
   endtask

   initial begin
      vec_t vecs[$];
      int   errInit, lastHits, lastAt, expRes, expRem, expErr;
      logic [1:0] rop;
      logic [W-1:0] ra, rb;

      vecs.push_back('{2'b00,  8'd13,  8'd11, 8, 143,   0, 0});
      vecs.push_back('{2'b01, 8'd200,   8'd7, 8,  28,   4, 0});
      vecs.push_back('{2'b10, 8'd200,   8'd0, 6,  14,   4, 0});
      vecs.push_back('{2'b01,  8'd50,   8'd0, 8,   0,   0, 1});
      vecs.push_back('{2'b00, 8'd255, 8'd255, 8, 65025, 0, 0});
      vecs.push_back('{2'b01, 8'd255,   8'd1, 8, 255,   0, 0});
      vecs.push_back('{2'b01,   8'd3, 8'd200, 8,   0,   3, 0});
      vecs.push_back('{2'b10, 8'd255,   8'd0, 4,  15,  30, 0});
      vecs.push_back('{2'b10,   8'd0,   8'd0, 4,   0,   0, 0});
      vecs.push_back('{2'b11,   8'd9,   8'd9, 8,   0,   0, 1});
      vecs.push_back('{2'b01,   8'd0,   8'd5, 8,   0,   0, 0});

      rst     = 1'b0;
      control = '0;
      opc     = 2'b00;
      a       = '0;
      b       = '0;
      tick();
      tick();
      checkOutput("reset_result", 32'(result), 0);
      checkOutput("reset_remainder", 32'(remainder), 0);
      checkOutput("reset_valid", 32'(valid), 0);
      checkOutput("reset_error", 32'(error), 0);
      checkOutput("reset_last_step", 32'(lastStep), 0);
      rst = 1'b1;
      tick();

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].steps, 1'b1, errInit, lastHits, lastAt);
         checkOutput($sformatf("vec%0d_error_init", i), 32'(errInit), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].expRes));
         checkOutput($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].expRem));
         checkOutput($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d_last_hits", i), 32'(lastHits), vecs[i].expErr ? 0 : 1);
         checkOutput($sformatf("vec%0d_last_at", i), 32'(lastAt),
                     vecs[i].expErr ? 32'hFFFF_FFFF : 32'(iterOf(vecs[i].op)));
         checkOutput($sformatf("vec%0d_valid", i), 32'(valid), 1);
         tick();
         checkOutput($sformatf("vec%0d_valid_drop", i), 32'(valid), 0);
      end

      // Reset in the middle of a multiply after a completed product is on the outputs.
      applyStimulus(2'b00, 8'd13, 8'd11, 8, 1'b1, errInit, lastHits, lastAt);
      checkOutput("pre_reset_result", 32'(result), 143);
      applyStimulus(2'b00, 8'd7, 8'd9, 4, 1'b0, errInit, lastHits, lastAt);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("midop_reset_result", 32'(result), 0);
      checkOutput("midop_reset_remainder", 32'(remainder), 0);
      checkOutput("midop_reset_valid", 32'(valid), 0);
      checkOutput("midop_reset_error", 32'(error), 0);
      checkOutput("midop_reset_last_step", 32'(lastStep), 0);
      applyStimulus(2'b00, 8'd3, 8'd5, 8, 1'b1, errInit, lastHits, lastAt);
      checkOutput("post_reset_result", 32'(result), 15);

      // init and step together: the step must be dropped so the count starts at zero.
      control      = '0;
      control.init = 1'b1;
      control.step = 1'b1;
      opc = 2'b00; a = 8'd13; b = 8'd11;
      tick();
      control = '0;
      lastAt  = -1;
      for (int i = 1; i <= 8; i++) begin
         control.step = 1'b1;
         #1;
         if (lastStep) lastAt = i;
         tick();
         control.step = 1'b0;
      end
      control.store = 1'b1;
      tick();
      control.store = 1'b0;
      checkOutput("init_step_last_at", 32'(lastAt), 8);
      checkOutput("init_step_result", 32'(result), 143);

      // store and step together: partial product stored, count left where it was.
      applyStimulus(2'b00, 8'd13, 8'd181, 4, 1'b0, errInit, lastHits, lastAt);
      control       = '0;
      control.store = 1'b1;
      control.step  = 1'b1;
      tick();
      control = '0;
      checkOutput("store_step_partial", 32'(result), 32'(13 * (181 % 16)));
      checkOutput("store_step_valid", 32'(valid), 1);
      lastAt = -1;
      for (int i = 1; i <= 6; i++) begin
         control.step = 1'b1;
         #1;
         if (lastStep) lastAt = i;
         tick();
         control.step = 1'b0;
      end
      control.store = 1'b1;
      tick();
      control.store = 1'b0;
      checkOutput("store_step_last_at", 32'(lastAt), 4);
      checkOutput("store_step_final", 32'(result), 13 * 181);

      for (int n = 0; n < 60; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = W'($urandom_range(0, 255));
         rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
         refModel(rop, int'(ra), int'(rb), expRes, expRem, expErr);
         applyStimulus(rop, ra, rb, iterOf(rop), 1'b1, errInit, lastHits, lastAt);
         checkOutput($sformatf("rnd%0d_op%0d_a%0d_b%0d_result", n, rop, ra, rb), 32'(result), 32'(expRes));
         checkOutput($sformatf("rnd%0d_op%0d_a%0d_b%0d_remainder", n, rop, ra, rb), 32'(remainder), 32'(expRem));
         checkOutput($sformatf("rnd%0d_error", n), 32'(error), 32'(expErr));
         checkOutput($sformatf("rnd%0d_valid", n), 32'(valid), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
